// File: rtl/eth_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one Ethernet II TX path (header + 32-bit payload)
// among N requesters; the winner's header then its whole payload up to tlast is forwarded.
module eth_tx_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*48-1:0]    s_dest,
  input  logic [N*48-1:0]    s_src,
  input  logic [N*16-1:0]    s_ttype,
  input  logic [N-1:0]       s_hvld,
  output logic [N-1:0]       s_hrdy,
  input  logic [N*32-1:0]    s_tdata,
  input  logic [N*4-1:0]     s_tkeep,
  input  logic [N-1:0]       s_tlast,
  input  logic [N-1:0]       s_tvalid,
  output logic [N-1:0]       s_tready,
  output logic [47:0]        m_dest,
  output logic [47:0]        m_src,
  output logic [15:0]        m_ttype,
  output logic               m_vld,
  input  logic               m_rdy,
  output logic [31:0]        m_tdata,
  output logic [3:0]         m_tkeep,
  output logic               m_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic [31:0]        pkt_count
);

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned TT_W   = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_grant, last_nxt, grant_nxt;
  logic [IDX_W-1:0]   rr_pick, rr_cand;
  logic               rr_found;
  logic [CNT_W-1:0]   cnt_nxt;

  // First requesting port scanning upward from the port after the last winner.
  always_comb begin
    rr_pick  = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      rr_cand = IDX_W'((32'(last_grant) + k) % N);
      if (!rr_found && s_hvld[rr_cand]) begin
        rr_pick  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(N - 1);
      pkt_count  <= '0;
    end else begin
      state      <= state_nxt;
      grant_idx  <= grant_nxt;
      last_grant <= last_nxt;
      pkt_count  <= cnt_nxt;
    end
  end

  // Next state plus the grant-steered header/payload muxes; idle channels drive zero.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    last_nxt  = last_grant;
    cnt_nxt   = pkt_count;
    m_dest    = '0;
    m_src     = '0;
    m_ttype   = '0;
    m_vld     = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    s_hrdy    = '0;
    s_tready  = '0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          grant_nxt = rr_pick;
          state_nxt = HDR;
        end
      end
      HDR: begin
        m_dest            = s_dest[32'(grant_idx) * MAC_W +: MAC_W];
        m_src             = s_src[32'(grant_idx) * MAC_W +: MAC_W];
        m_ttype           = s_ttype[32'(grant_idx) * TT_W +: TT_W];
        m_vld             = s_hvld[grant_idx];
        s_hrdy[grant_idx] = m_rdy;
        if (m_vld && m_rdy) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        m_tdata             = s_tdata[32'(grant_idx) * DATA_W +: DATA_W];
        m_tkeep             = s_tkeep[32'(grant_idx) * KEEP_W +: KEEP_W];
        m_tlast             = s_tlast[grant_idx];
        m_tvalid            = s_tvalid[grant_idx];
        s_tready[grant_idx] = m_tready;
        if (m_tvalid && m_tready && m_tlast) begin
          cnt_nxt   = pkt_count + CNT_W'(1);
          last_nxt  = grant_idx;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: behavioural requesters plus a packet-level round-robin reference,
// directed scenarios followed by a randomized run with sporadic resets.
module tb_eth_tx_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*48-1:0] s_dest, s_src;
  logic [N*16-1:0] s_ttype;
  logic [N-1:0]    s_hvld, s_hrdy, s_tlast, s_tvalid, s_tready;
  logic [N*32-1:0] s_tdata;
  logic [N*4-1:0]  s_tkeep;
  logic [47:0]     m_dest, m_src;
  logic [15:0]     m_ttype;
  logic            m_vld, m_rdy, m_tlast, m_tvalid, m_tready;
  logic [31:0]     m_tdata;
  logic [3:0]      m_tkeep;
  logic [IW-1:0]   grant_idx;
  logic            busy;
  logic [31:0]     pkt_count;

  eth_tx_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .s_dest(s_dest), .s_src(s_src), .s_ttype(s_ttype), .s_hvld(s_hvld), .s_hrdy(s_hrdy),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_dest(m_dest), .m_src(m_src), .m_ttype(m_ttype), .m_vld(m_vld), .m_rdy(m_rdy),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Requester state
  logic [47:0] sd[N], ss[N];
  logic [15:0] st[N];
  logic [31:0] sdat[N];
  logic [3:0]  skeep[N];
  bit          has_pkt[N], hdr_done[N], tv[N];
  int          left[N];

  // Knobs
  logic [N-1:0] start_mask = '0;
  int  p_start = 0, p_tvalid = 100, fixed_len = 0;
  int  rdy_mode = 0, trdy_mode = 0;
  bit  rst_now = 1'b0, chk_en = 1'b0, tog = 1'b0;

  // Reference: phase 0 idle / 1 header / 2 payload, plus grant, last winner, packet count
  int          ph = 0, mg = 0, ml = N - 1;
  logic [31:0] mp = '0;

  int gq[$];
  int obs_beats = 0, obs_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Winner = requesting port at the smallest forward distance from the previous winner.
  function automatic int rr_choose(input logic [N-1:0] req, input int last);
    int best = -1;
    int bd   = N + 1;
    for (int p = 0; p < N; p++) begin
      int d = (p - last - 1 + 2 * N) % N;
      if (req[p] && d < bd) begin
        bd   = d;
        best = p;
      end
    end
    return best;
  endfunction

  function automatic logic mode_val(input int md);
    case (md)
      0: return 1'b1;
      1: return 1'($urandom_range(1));
      2: return 1'b0;
      default: return tog;
    endcase
  endfunction

  task automatic new_beat(input int p);
    sdat[p]  = $urandom();
    skeep[p] = 4'($urandom());
  endtask

  task automatic cycle();
    int nph = ph;
    int nmg = mg;
    int nml = ml;
    logic [31:0] nmp = mp;
    logic [N-1:0] e_hrdy, e_trdy;
    for (int p = 0; p < N; p++) begin
      if (!has_pkt[p] && start_mask[p] && $urandom_range(99) < p_start) begin
        has_pkt[p]  = 1'b1;
        hdr_done[p] = 1'b0;
        left[p]     = (fixed_len != 0) ? fixed_len : int'($urandom_range(5, 1));
        sd[p]       = 48'({$urandom(), $urandom()});
        ss[p]       = 48'({$urandom(), $urandom()});
        st[p]       = 16'($urandom());
        new_beat(p);
      end
      tv[p] = ($urandom_range(99) < p_tvalid);
      s_dest[p*48 +: 48]  = sd[p];
      s_src[p*48 +: 48]   = ss[p];
      s_ttype[p*16 +: 16] = st[p];
      s_tdata[p*32 +: 32] = sdat[p];
      s_tkeep[p*4 +: 4]   = skeep[p];
      s_hvld[p]   = has_pkt[p] && !hdr_done[p];
      s_tvalid[p] = has_pkt[p] && tv[p];
      s_tlast[p]  = has_pkt[p] && (left[p] == 1);
    end
    m_rdy    = mode_val(rdy_mode);
    m_tready = mode_val(trdy_mode);
    reset    = rst_now;
    #1;
    if (chk_en) begin
      e_hrdy = '0;
      e_trdy = '0;
      if (ph == 1) e_hrdy[mg] = m_rdy;
      if (ph == 2) e_trdy[mg] = m_tready;
      check("busy", 64'(busy), 64'(ph != 0));
      check("grant_idx", 64'(grant_idx), 64'(mg));
      check("pkt_count", 64'(pkt_count), 64'(mp));
      check("m_vld", 64'(m_vld), 64'(ph == 1 && s_hvld[mg]));
      check("s_hrdy", 64'(s_hrdy), 64'(e_hrdy));
      check("m_tvalid", 64'(m_tvalid), 64'(ph == 2 && s_tvalid[mg]));
      check("s_tready", 64'(s_tready), 64'(e_trdy));
      if (ph == 1) begin
        check("m_dest", 64'(m_dest), 64'(sd[mg]));
        check("m_src", 64'(m_src), 64'(ss[mg]));
        check("m_ttype", 64'(m_ttype), 64'(st[mg]));
      end
      if (ph == 2 && s_tvalid[mg]) begin
        check("m_tdata", 64'(m_tdata), 64'(sdat[mg]));
        check("m_tkeep", 64'(m_tkeep), 64'(skeep[mg]));
        check("m_tlast", 64'(m_tlast), 64'(left[mg] == 1));
      end else if (ph != 2) begin
        check("m_tlast_idle", 64'(m_tlast), 64'(0));
      end
      if (m_tvalid && m_tready) begin
        obs_beats++;
        if (m_tlast) obs_last++;
      end
    end
    if (rst_now) begin
      nph = 0; nmg = 0; nml = N - 1; nmp = '0;
      for (int p = 0; p < N; p++) begin
        has_pkt[p]  = 1'b0;
        hdr_done[p] = 1'b0;
      end
    end else begin
      case (ph)
        0: if (s_hvld != '0) begin
          nmg = rr_choose(s_hvld, ml);
          nph = 1;
        end
        1: if (s_hvld[mg] && m_rdy) begin
          gq.push_back(int'(grant_idx));
          hdr_done[mg] = 1'b1;
          nph = 2;
        end
        default: if (s_tvalid[mg] && m_tready) begin
          if (left[mg] == 1) begin
            nmp = mp + 32'd1;
            nml = mg;
            nph = 0;
            has_pkt[mg] = 1'b0;
          end else begin
            left[mg] = left[mg] - 1;
            new_beat(mg);
          end
        end
      endcase
    end
    @(posedge clk);
    ph = nph; mg = nmg; ml = nml; mp = nmp;
    tog = ~tog;
    #1;
  endtask

  task automatic any_pending(output bit pend);
    pend = (ph != 0);
    for (int p = 0; p < N; p++) if (has_pkt[p]) pend = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bit pend;
    start_mask = '0;
    any_pending(pend);
    while (pend && k < 400) begin
      cycle();
      k++;
      any_pending(pend);
    end
    check(tag, 64'(k < 400), 64'(1));
  endtask

  task automatic do_reset(input int n);
    rst_now = 1'b1;
    repeat (n) cycle();
    rst_now = 1'b0;
    gq.delete();
    obs_beats = 0;
    obs_last  = 0;
  endtask

  initial begin
    int k;
    for (int p = 0; p < N; p++) begin
      sd[p] = '0; ss[p] = '0; st[p] = '0; sdat[p] = '0; skeep[p] = '0;
      has_pkt[p] = 1'b0; hdr_done[p] = 1'b0; tv[p] = 1'b0; left[p] = 0;
    end

    // Reset state, all outputs quiet
    rst_now = 1'b1;
    cycle();
    chk_en = 1'b1;
    do_reset(2);
    check("rst_m_dest", 64'(m_dest), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    check("rst_m_ttype", 64'(m_ttype), 64'(0));

    // Both ports request right out of reset: port 0 first, port 1 next
    start_mask = 3'b011; p_start = 100; fixed_len = 2;
    cycle();
    drain("t1_drain");
    check("t1_n_grants", 64'(gq.size()), 64'(2));
    if (gq.size() >= 2) begin
      check("t1_first", 64'(gq[0]), 64'(0));
      check("t1_second", 64'(gq[1]), 64'(1));
    end

    // Port 1 four-beat packet under toggling m_tready
    do_reset(1);
    start_mask = 3'b010; fixed_len = 4; trdy_mode = 3;
    cycle();
    drain("t2_drain");
    check("t2_beats", 64'(obs_beats), 64'(4));
    check("t2_tlast", 64'(obs_last), 64'(1));
    check("t2_pkt_count", 64'(pkt_count), 64'(1));

    // Header back-pressure for five cycles
    do_reset(1);
    trdy_mode = 0; rdy_mode = 2; start_mask = 3'b001; fixed_len = 3;
    cycle();
    start_mask = '0;
    repeat (5) cycle();
    check("t3_m_vld_held", 64'(m_vld), 64'(1));
    check("t3_hrdy_low", 64'(s_hrdy), 64'(0));
    rdy_mode = 0;
    drain("t3_drain");

    // All ports requesting continuously: strict rotation over 3N packets
    do_reset(1);
    start_mask = '1; fixed_len = 0; p_tvalid = 70; rdy_mode = 1; trdy_mode = 1;
    k = 0;
    while (mp < 32'(3 * N) && k < 3000) begin
      cycle();
      k++;
    end
    check("t4_pkt_count", 64'(pkt_count), 64'(3 * N));
    check("t4_n_grants", 64'(gq.size() >= 3 * N), 64'(1));
    for (int i = 0; i < 3 * N && i < gq.size(); i++) check("t4_rotation", 64'(gq[i]), 64'(i % N));
    drain("t4_drain");

    // Port 2 requests mid-packet of port 0: waits until port 0 completes
    do_reset(1);
    start_mask = 3'b001; fixed_len = 4; p_tvalid = 100; rdy_mode = 0; trdy_mode = 0;
    cycle();
    start_mask = '0;
    repeat (3) cycle();
    start_mask = 3'b100;
    cycle();
    drain("t5_drain");
    check("t5_n_grants", 64'(gq.size()), 64'(2));
    if (gq.size() >= 2) begin
      check("t5_first", 64'(gq[0]), 64'(0));
      check("t5_second", 64'(gq[1]), 64'(2));
    end

    // Reset on beat 2 of 4 drops the packet
    do_reset(1);
    start_mask = 3'b001; fixed_len = 4;
    cycle();
    start_mask = '0;
    repeat (2) cycle();
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b0;
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_pkt_count", 64'(pkt_count), 64'(0));
    check("t6_tready", 64'(s_tready), 64'(0));
    check("t6_tvalid", 64'(m_tvalid), 64'(0));
    check("t6_hrdy", 64'(s_hrdy), 64'(0));
    check("t6_vld", 64'(m_vld), 64'(0));
    cycle();

    // Randomized traffic with sporadic resets
    fixed_len = 0; p_tvalid = 60; p_start = 25; rdy_mode = 1; trdy_mode = 1;
    start_mask = '1;
    for (int i = 0; i < 1500; i++) begin
      rst_now = ($urandom_range(299) == 0);
      cycle();
    end
    rst_now = 1'b0;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
